// File: rtl/stream_arb_pkg.sv
// rtl/stream_arb_pkg.sv - shared constants and helpers for the packet arbiter
package stream_arb_pkg;

  localparam logic ARB_IDLE = 1'b0;
  localparam logic ARB_PASS = 1'b1;

  localparam int AXIS_ID_W   = 5;
  localparam int AXIS_DEST_W = 5;

  // Index width for a port count; never below 1 so a 2-port build still has a bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority picker
module rr_pick
  import stream_arb_pkg::*;
#(
  parameter  int NUM_PORTS = 4,
  localparam int IDX_W     = clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] eligible,
  input  logic [IDX_W-1:0]     last_grant,
  output logic [NUM_PORTS-1:0] pick,
  output logic [IDX_W-1:0]     pick_idx,
  output logic                 any_valid
);

  // Scan starts one past the previous winner so that port ends up lowest priority.
  always_comb begin
    int  cand;
    logic found;
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    cand     = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = (int'(last_grant) + k) % NUM_PORTS;
      if (!found && eligible[cand]) begin
        pick[cand] = 1'b1;
        pick_idx   = IDX_W'(cand);
        found      = 1'b1;
      end
    end
  end

  assign any_valid = |eligible;

endmodule

// File: rtl/stream_pkt_arbiter.sv
// rtl/stream_pkt_arbiter.sv - packet-atomic round-robin AXI-Stream arbiter
module stream_pkt_arbiter
  import stream_arb_pkg::*;
#(
  parameter  int NUM_PORTS = 4,
  parameter  int TBYTE_NUM = 16,
  localparam int IDX_W     = clog2(NUM_PORTS),
  localparam int DATA_W    = TBYTE_NUM * 8
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             arb_en,
  input  logic [NUM_PORTS-1:0]             req_mask,
  input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
  output logic [NUM_PORTS-1:0]             s_axis_tready,
  input  logic [NUM_PORTS*DATA_W-1:0]      s_axis_tdata,
  input  logic [NUM_PORTS*TBYTE_NUM-1:0]   s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]             s_axis_tlast,
  input  logic [NUM_PORTS*AXIS_ID_W-1:0]   s_axis_tid,
  input  logic [NUM_PORTS*AXIS_DEST_W-1:0] s_axis_tdest,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [DATA_W-1:0]                m_axis_tdata,
  output logic [TBYTE_NUM-1:0]             m_axis_tkeep,
  output logic                             m_axis_tlast,
  output logic [AXIS_ID_W-1:0]             m_axis_tid,
  output logic [AXIS_DEST_W-1:0]           m_axis_tdest,
  output logic [NUM_PORTS-1:0]             arb_grant,
  output logic                             arb_busy,
  output logic                             pkt_done,
  output logic [IDX_W-1:0]                 pkt_src
);

  logic                 state;
  logic                 state_nxt;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W-1:0]     last_grant;
  logic [NUM_PORTS-1:0] eligible;
  logic [NUM_PORTS-1:0] pick;
  logic [IDX_W-1:0]     pick_idx;
  logic                 any_valid;
  logic                 start;
  logic                 beat_done;

  assign eligible  = s_axis_tvalid & ~req_mask;
  assign start     = arb_en & any_valid;
  assign beat_done = m_axis_tvalid & m_axis_tready & m_axis_tlast;
  assign arb_busy  = (state == ARB_PASS);

  rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
    .eligible   (eligible),
    .last_grant (last_grant),
    .pick       (pick),
    .pick_idx   (pick_idx),
    .any_valid  (any_valid)
  );

  always_ff @(posedge clk) begin
    if (!rstn) state <= ARB_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: if (start)     state_nxt = ARB_PASS;
      ARB_PASS: if (beat_done) state_nxt = ARB_IDLE;
      default:                 state_nxt = ARB_IDLE;
    endcase
  end

  // Grant and pointer registers; the pointer resets so port 0 is scanned first.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      arb_grant  <= '0;
      grant_idx  <= '0;
      last_grant <= IDX_W'(NUM_PORTS - 1);
      pkt_done   <= 1'b0;
      pkt_src    <= '0;
    end else begin
      pkt_done <= 1'b0;
      if (state == ARB_IDLE && start) begin
        arb_grant  <= pick;
        grant_idx  <= pick_idx;
        last_grant <= pick_idx;
      end
      if (state == ARB_PASS && beat_done) begin
        arb_grant <= '0;
        pkt_done  <= 1'b1;
        pkt_src   <= grant_idx;
      end
    end
  end

  // Forwarding is gated by rstn so nothing handshakes during the reset cycle.
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tid    = '0;
    m_axis_tdest  = '0;
    s_axis_tready = '0;
    if (rstn && state == ARB_PASS) begin
      m_axis_tvalid = s_axis_tvalid[grant_idx];
      m_axis_tdata  = s_axis_tdata[grant_idx*DATA_W +: DATA_W];
      m_axis_tkeep  = s_axis_tkeep[grant_idx*TBYTE_NUM +: TBYTE_NUM];
      m_axis_tlast  = s_axis_tlast[grant_idx];
      m_axis_tid    = s_axis_tid[grant_idx*AXIS_ID_W +: AXIS_ID_W];
      m_axis_tdest  = s_axis_tdest[grant_idx*AXIS_DEST_W +: AXIS_DEST_W];
      s_axis_tready = arb_grant & {NUM_PORTS{m_axis_tready}};
    end
  end

endmodule

// File: tb/tb_stream_pkt_arbiter.sv
// tb/tb_stream_pkt_arbiter.sv - randomized bench with behavioural arbiter model
module tb_stream_pkt_arbiter;

  localparam int N  = 4;
  localparam int TB = 16;
  localparam int DW = TB * 8;

  logic            clk = 1'b0;
  logic            rstn;
  logic            arb_en;
  logic [N-1:0]    req_mask;
  logic [N-1:0]    s_axis_tvalid;
  logic [N-1:0]    s_axis_tready;
  logic [N*DW-1:0] s_axis_tdata;
  logic [N*TB-1:0] s_axis_tkeep;
  logic [N-1:0]    s_axis_tlast;
  logic [N*5-1:0]  s_axis_tid;
  logic [N*5-1:0]  s_axis_tdest;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic [DW-1:0]   m_axis_tdata;
  logic [TB-1:0]   m_axis_tkeep;
  logic            m_axis_tlast;
  logic [4:0]      m_axis_tid;
  logic [4:0]      m_axis_tdest;
  logic [N-1:0]    arb_grant;
  logic            arb_busy;
  logic            pkt_done;
  logic [1:0]      pkt_src;

  always #5 clk = ~clk;

  stream_pkt_arbiter #(.NUM_PORTS(N), .TBYTE_NUM(TB)) dut (
    .clk(clk), .rstn(rstn), .arb_en(arb_en), .req_mask(req_mask),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast), .s_axis_tid(s_axis_tid), .s_axis_tdest(s_axis_tdest),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid), .m_axis_tdest(m_axis_tdest),
    .arb_grant(arb_grant), .arb_busy(arb_busy), .pkt_done(pkt_done), .pkt_src(pkt_src)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [TB-1:0] keep;
    logic          last;
    logic [4:0]    id;
    logic [4:0]    dest;
  } beat_t;

  beat_t srcq[N][$];
  bit    holding[N];
  bit    rand_mode = 1'b0;
  int    acc_port  = -1;

  int    owner    = -1;
  int    ptr      = N - 1;
  bit    exp_done = 1'b0;
  int    exp_src  = 0;

  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  int    done_log[$];
  logic [7:0] beat_log[$];
  logic [N-1:0] first_grant;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 20) $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: owner of the sink and the round-robin pointer, updated per edge.
  initial begin
    logic [N-1:0] eg;
    bit pass;
    bit ev;
    forever begin
      @(negedge clk);
      cyc++;
      eg   = (owner >= 0) ? N'(1 << owner) : '0;
      pass = (owner >= 0) && (rstn === 1'b1);
      ev   = pass ? s_axis_tvalid[owner] : 1'b0;
      chk("arb_grant", DW'(arb_grant), DW'(eg));
      chk("arb_busy", DW'(arb_busy), DW'(owner >= 0));
      chk("m_tvalid", DW'(m_axis_tvalid), DW'(ev));
      chk("s_tready", DW'(s_axis_tready), DW'((pass && m_axis_tready) ? eg : '0));
      chk("pkt_done", DW'(pkt_done), DW'(exp_done));
      chk("pkt_src", DW'(pkt_src), DW'(exp_src));
      if (!pass || ev) begin
        chk("m_tdata", m_axis_tdata, pass ? s_axis_tdata[owner*DW +: DW] : '0);
        chk("m_tkeep", DW'(m_axis_tkeep), DW'(pass ? s_axis_tkeep[owner*TB +: TB] : '0));
        chk("m_tlast", DW'(m_axis_tlast), DW'(pass ? s_axis_tlast[owner] : 1'b0));
        chk("m_tid", DW'(m_axis_tid), DW'(pass ? s_axis_tid[owner*5 +: 5] : 5'd0));
        chk("m_tdest", DW'(m_axis_tdest), DW'(pass ? s_axis_tdest[owner*5 +: 5] : 5'd0));
      end
      if (m_axis_tvalid && m_axis_tready) beat_log.push_back(m_axis_tdata[7:0]);
      if (pkt_done) done_log.push_back(int'(pkt_src));
      if (arb_grant != '0 && first_grant == '0) first_grant = arb_grant;

      @(posedge clk);
      acc_port = (pass && ev && m_axis_tready) ? owner : -1;
      if (!rstn) begin
        owner = -1; ptr = N - 1; exp_done = 1'b0; exp_src = 0;
      end else begin
        exp_done = 1'b0;
        if (owner < 0) begin
          if (arb_en) begin
            for (int k = 1; k <= N; k++) begin
              int p;
              p = (ptr + k) % N;
              if (owner < 0 && s_axis_tvalid[p] && !req_mask[p]) begin
                owner = p;
                ptr   = p;
              end
            end
          end
        end else if (acc_port >= 0 && s_axis_tlast[owner]) begin
          exp_done = 1'b1;
          exp_src  = owner;
          owner    = -1;
        end
      end
    end
  end

  task automatic push_pkt(input int p, input int len, input logic [31:0] base);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = rand_mode ? {$urandom, $urandom, $urandom, base + 32'(i)} : DW'(base + 32'(i));
      b.keep = rand_mode ? TB'($urandom) : '1;
      b.last = (i == len - 1);
      b.id   = 5'(p);
      b.dest = 5'(i);
      srcq[p].push_back(b);
    end
  endtask

  task automatic drive();
    for (int p = 0; p < N; p++) begin
      bit show;
      show = (srcq[p].size() > 0) && (holding[p] || !rand_mode || ($urandom % 4) != 0);
      holding[p] = show;
      s_axis_tvalid[p] = show;
      s_axis_tdata[p*DW +: DW] = show ? srcq[p][0].data : '0;
      s_axis_tkeep[p*TB +: TB] = show ? srcq[p][0].keep : '0;
      s_axis_tlast[p]          = show ? srcq[p][0].last : 1'b0;
      s_axis_tid[p*5 +: 5]     = show ? srcq[p][0].id : 5'd0;
      s_axis_tdest[p*5 +: 5]   = show ? srcq[p][0].dest : 5'd0;
    end
  endtask

  task automatic clear_srcs();
    for (int p = 0; p < N; p++) begin
      srcq[p].delete();
      holding[p] = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (acc_port >= 0) begin
      srcq[acc_port].delete(0);
      holding[acc_port] = 1'b0;
    end
    if (rand_mode) begin
      m_axis_tready = ($urandom % 4) != 0;
      arb_en        = ($urandom % 8) != 0;
      if ($urandom % 16 == 0) req_mask = N'($urandom);
      if (!rstn) rstn = 1'b1;
      else if ($urandom % 500 == 0) begin
        rstn = 1'b0;
        clear_srcs();
      end
      for (int p = 0; p < N; p++)
        if (rstn && srcq[p].size() == 0 && $urandom % 3 == 0)
          push_pkt(p, 1 + int'($urandom % 4), $urandom);
    end
    drive();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    clear_srcs();
    drive();
    @(negedge clk);
    chk("rst_m_tvalid", DW'(m_axis_tvalid), '0);
    chk("rst_s_tready", DW'(s_axis_tready), '0);
    step();
    rstn = 1'b1;
  endtask

  task automatic clear_logs();
    beat_log.delete();
    done_log.delete();
    first_grant = '0;
  endtask

  initial begin
    int exp3[6];
    exp3 = '{0, 2, 3, 0, 2, 3};
    rstn = 1'b0; arb_en = 1'b1; req_mask = '0; m_axis_tready = 1'b0;
    clear_srcs();
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_grant", DW'(arb_grant), '0);
    chk("reset_busy", DW'(arb_busy), '0);
    chk("reset_done", DW'(pkt_done), '0);
    chk("reset_src", DW'(pkt_src), '0);

    // Single 3-beat packet from port 1.
    step();
    rstn = 1'b1; m_axis_tready = 1'b1;
    clear_logs();
    push_pkt(1, 3, 32'h10);
    drive();
    repeat (10) step();
    chk("p1_first_grant", DW'(first_grant), DW'(4'b0010));
    chk("p1_beats", DW'(beat_log.size()), DW'(3));
    for (int i = 0; i < beat_log.size() && i < 3; i++)
      chk("p1_beat_data", DW'(beat_log[i]), DW'(8'h10 + 8'(i)));
    chk("p1_done_cnt", DW'(done_log.size()), DW'(1));
    if (done_log.size() > 0) chk("p1_done_src", DW'(done_log[0]), DW'(1));
    chk("p1_grant_clear", DW'(arb_grant), '0);

    // Ports 0,2,3 with two 2-beat packets each, all pending right after reset.
    do_reset();
    clear_logs();
    for (int r = 0; r < 2; r++) begin
      push_pkt(0, 2, 32'h100 + 32'(r * 16));
      push_pkt(2, 2, 32'h200 + 32'(r * 16));
      push_pkt(3, 2, 32'h300 + 32'(r * 16));
    end
    drive();
    repeat (30) step();
    chk("rr_done_cnt", DW'(done_log.size()), DW'(6));
    for (int i = 0; i < done_log.size() && i < 6; i++)
      chk("rr_order", DW'(done_log[i]), DW'(exp3[i]));

    // arb_en dropped mid-packet: port 2 finishes, port 3 waits.
    clear_logs();
    push_pkt(2, 5, 32'h20);
    push_pkt(3, 1, 32'h30);
    drive();
    repeat (2) step();
    arb_en = 1'b0;
    repeat (12) step();
    chk("en_done_cnt", DW'(done_log.size()), DW'(1));
    if (done_log.size() > 0) chk("en_done_src", DW'(done_log[0]), DW'(2));
    chk("en_hold_idle", DW'(arb_grant), '0);
    arb_en = 1'b1;
    step();
    @(negedge clk);
    chk("en_resume_grant", DW'(arb_grant), DW'(4'b1000));
    repeat (4) step();

    // Reset in the middle of a port-1 packet, then ports 1 and 3 compete.
    clear_logs();
    push_pkt(1, 5, 32'h40);
    drive();
    repeat (4) step();
    do_reset();
    clear_logs();
    push_pkt(3, 1, 32'h50);
    push_pkt(1, 1, 32'h60);
    drive();
    repeat (8) step();
    chk("rst_done_cnt", DW'(done_log.size()), DW'(2));
    if (done_log.size() > 1) begin
      chk("rst_first_src", DW'(done_log[0]), DW'(1));
      chk("rst_second_src", DW'(done_log[1]), DW'(3));
    end

    // Randomized traffic with masks, stalls, arb_en gaps and rare resets.
    rand_mode = 1'b1;
    repeat (4000) step();
    rand_mode = 1'b0;
    rstn = 1'b1; arb_en = 1'b1; req_mask = '0; m_axis_tready = 1'b1;
    drive();
    repeat (60) step();
    chk("drain_idle", DW'(arb_grant), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
